// File: rtl/tap_delay_line_if.sv
// rtl/tap_delay_line_if.sv - control, data and tap-select signal bundle for tap_delay_line
//
// Signals:
//   ce       shift enable
//   flush    synchronous clear of stage valid bits and fill counter
//   d        input word, WIDTH bits
//   d_valid  qualifies d
//   sel      tap select, SELW bits (0 = bypass, k = stage k)
//   q        selected tap data
//   q_valid  valid bit of selected tap
//   fill     number of stages holding valid data
// Modports: master drives d/ctrl/sel and reads q/fill; slave is the delay line.

interface tap_delay_line_if #(
    parameter int WIDTH = 8,
    parameter int SELW  = 2
);
    logic             ce;
    logic             flush;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic [SELW-1:0]  sel;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [SELW-1:0]  fill;

    modport master (
        output ce, flush, d, d_valid, sel,
        input  q, q_valid, fill
    );

    modport slave (
        input  ce, flush, d, d_valid, sel,
        output q, q_valid, fill
    );
endinterface

// File: rtl/tap_delay_line.sv
// rtl/tap_delay_line.sv - clock-enabled programmable delay line with valid tracking and fill count
//
// Parameters: WIDTH (word width), DEPTH (stages), SELW (derived tap-select width).
// Ports:
//   clk       rising-edge clock
//   areset_n  asynchronous active-low reset
//   bus       tap_delay_line_if.slave (ce, flush, d, d_valid, sel -> q, q_valid, fill)
// Build option: define TAP_DELAY_LINE_OUT_REG_EN to register q/q_valid after the tap mux.

module tap_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int SELW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             areset_n,
    tap_delay_line_if.slave  bus
);
    localparam logic [SELW-1:0] DEPTH_SEL = SELW'(DEPTH);

    logic [WIDTH-1:0] s_data [1:DEPTH];
    logic [DEPTH:1]   s_valid;
    logic [SELW-1:0]  fill_r;
    logic [SELW-1:0]  fill_next;
    logic [SELW-1:0]  sel_eff;
    logic [WIDTH-1:0] tap_data;
    logic             tap_valid;

    // Fill moves by +1 when a valid word enters and no valid word leaves the
    // last stage, -1 for the opposite; this tracks the popcount of s_valid.
    always_comb begin
        fill_next = fill_r;
        if (bus.d_valid && !s_valid[DEPTH] && (fill_r != DEPTH_SEL))
            fill_next = fill_r + SELW'(1);
        else if (!bus.d_valid && s_valid[DEPTH] && (fill_r != '0))
            fill_next = fill_r - SELW'(1);
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int k = 1; k <= DEPTH; k++)
                s_data[k] <= '0;
            s_valid <= '0;
            fill_r  <= '0;
        end else if (bus.flush) begin
            // Data is left in place; only the qualifiers are dropped.
            s_valid <= '0;
            fill_r  <= '0;
        end else if (bus.ce) begin
            s_data[1]  <= bus.d;
            s_valid[1] <= bus.d_valid;
            for (int k = 2; k <= DEPTH; k++) begin
                s_data[k]  <= s_data[k-1];
                s_valid[k] <= s_valid[k-1];
            end
            fill_r <= fill_next;
        end
    end

    // Out-of-range selects clamp to the last stage rather than wrapping.
    assign sel_eff = (bus.sel > DEPTH_SEL) ? DEPTH_SEL : bus.sel;

    always_comb begin
        tap_data  = bus.d;
        tap_valid = bus.d_valid;
        for (int k = 1; k <= DEPTH; k++) begin
            if (sel_eff == SELW'(k)) begin
                tap_data  = s_data[k];
                tap_valid = s_valid[k];
            end
        end
    end

`ifdef TAP_DELAY_LINE_OUT_REG_EN
    logic [WIDTH-1:0] q_r;
    logic             q_valid_r;

    // Output register runs every edge, independent of ce.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            q_r       <= '0;
            q_valid_r <= 1'b0;
        end else begin
            q_r       <= tap_data;
            q_valid_r <= tap_valid & ~bus.flush;
        end
    end

    assign bus.q       = q_r;
    assign bus.q_valid = q_valid_r;
`else
    assign bus.q       = tap_data;
    assign bus.q_valid = tap_valid;
`endif

    assign bus.fill = fill_r;
endmodule

// File: tb/tb_tap_delay_line.sv
// tb/tb_tap_delay_line.sv - randomized self-checking bench for tap_delay_line (DEPTH=3 and DEPTH=5)

module tb_tap_delay_line;
    typedef struct packed {
        logic [7:0] dat;
        logic       vld;
    } ent_t;

    logic       clk = 1'b0;
    logic       areset_n = 1'b0;
    logic       ce = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] d = 8'h00;
    logic       dv = 1'b0;
    logic [1:0] sel3 = 2'd0;
    logic [2:0] sel5 = 3'd0;

    int n_cmp = 0;
    int n_bad = 0;

    ent_t hist[$];
    ent_t oreg3 = '0;
    ent_t oreg5 = '0;

    tap_delay_line_if #(.WIDTH(8), .SELW(2)) bus3 ();
    tap_delay_line_if #(.WIDTH(8), .SELW(3)) bus5 ();

    assign bus3.ce = ce;  assign bus3.flush = flush; assign bus3.d = d; assign bus3.d_valid = dv; assign bus3.sel = sel3;
    assign bus5.ce = ce;  assign bus5.flush = flush; assign bus5.d = d; assign bus5.d_valid = dv; assign bus5.sel = sel5;

    tap_delay_line #(.WIDTH(8), .DEPTH(3)) dut3 (.clk(clk), .areset_n(areset_n), .bus(bus3));
    tap_delay_line #(.WIDTH(8), .DEPTH(5)) dut5 (.clk(clk), .areset_n(areset_n), .bus(bus5));

    always #5 clk = ~clk;

    // Reference: history of accepted words, newest first; tap k is the word
    // accepted k enabled edges ago.
    function automatic ent_t mtap(input int sel, input int depth);
        int k;
        ent_t e;
        k = (sel > depth) ? depth : sel;
        if (k == 0) begin
            e.dat = d; e.vld = dv;
        end else if (hist.size() >= k) begin
            e = hist[k-1];
        end else begin
            e = '0;
        end
        return e;
    endfunction

    function automatic int mfill(input int depth);
        int n = 0;
        for (int i = 0; i < hist.size() && i < depth; i++)
            if (hist[i].vld) n++;
        return n;
    endfunction

    function automatic ent_t exp_out(input int sel, input int depth);
`ifdef TAP_DELAY_LINE_OUT_REG_EN
        return (depth == 3) ? oreg3 : oreg5;
`else
        return mtap(sel, depth);
`endif
    endfunction

    task automatic tick();
        ent_t t3, t5, e;
        if (areset_n) begin
            t3 = mtap(int'(sel3), 3);
            t5 = mtap(int'(sel5), 5);
            if (flush) begin t3.vld = 1'b0; t5.vld = 1'b0; end
            oreg3 = t3;
            oreg5 = t5;
            if (flush) begin
                foreach (hist[i]) hist[i].vld = 1'b0;
            end else if (ce) begin
                e.dat = d; e.vld = dv;
                hist.push_front(e);
                if (hist.size() > 8) void'(hist.pop_back());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset_assert();
        areset_n = 1'b0;
        hist.delete();
        oreg3 = '0;
        oreg5 = '0;
    endtask

    task automatic test_reset();
        ent_t e;
        ce = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom); dv = 1'b1; sel3 = 2'd2; sel5 = 3'd2;
            tick();
        end
        #2;
        do_reset_assert();
        #1;
        n_cmp++;
        if (bus3.q !== 8'h00 || bus3.q_valid !== 1'b0 || bus3.fill !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_async3: got q=%h v=%b fill=%0d, expected q=00 v=0 fill=0", bus3.q, bus3.q_valid, bus3.fill);
        end
        n_cmp++;
        if (bus5.q !== 8'h00 || bus5.q_valid !== 1'b0 || bus5.fill !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_async5: got q=%h v=%b fill=%0d, expected q=00 v=0 fill=0", bus5.q, bus5.q_valid, bus5.fill);
        end
        tick();
        #2;
        areset_n = 1'b1;
        ce = 1'b1; d = 8'hA5; dv = 1'b1;
        tick();
        d = 8'($urandom); dv = 1'b0;
        tick();
`ifdef TAP_DELAY_LINE_OUT_REG_EN
        tick();
`endif
        n_cmp++;
        if (bus3.q !== 8'hA5 || bus3.q_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_latency: got q=%h v=%b, expected q=a5 v=1", bus3.q, bus3.q_valid);
        end
        e = exp_out(int'(sel3), 3);
        n_cmp++;
        if (e.vld !== bus3.q_valid || bus3.fill !== 2'(mfill(3))) begin
            n_bad++;
            $display("FAIL reset_model: got v=%b fill=%0d, expected v=%b fill=%0d", bus3.q_valid, bus3.fill, e.vld, mfill(3));
        end
    endtask

    task automatic test_sweep();
        ent_t e;
        for (int s = 0; s <= 3; s++) begin
            sel3 = 2'(s); sel5 = 3'(s);
            for (int i = 1; i <= 6; i++) begin
                ce = 1'b1; dv = 1'b1;
                d = (i <= 4) ? 8'(i) : 8'($urandom);
                tick();
                e = exp_out(s, 3);
                n_cmp++;
                if (bus3.q_valid !== e.vld || (e.vld && bus3.q !== e.dat)) begin
                    n_bad++;
                    $display("FAIL sweep sel=%0d i=%0d: got q=%h v=%b, expected q=%h v=%b", s, i, bus3.q, bus3.q_valid, e.dat, e.vld);
                end
            end
        end
`ifndef TAP_DELAY_LINE_OUT_REG_EN
        sel3 = 2'd0; d = 8'h5C; dv = 1'b1;
        #1;
        n_cmp++;
        if (bus3.q !== 8'h5C || bus3.q_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL bypass: got q=%h v=%b, expected q=5c v=1", bus3.q, bus3.q_valid);
        end
`endif
    endtask

    task automatic test_ce_gating();
        logic [7:0] sq;
        logic       sv;
        logic [1:0] sf;
        ent_t       e;
        sel3 = 2'd1; sel5 = 3'd2;
        ce = 1'b1; dv = 1'b1; d = 8'h11; tick();
        d = 8'h22; tick();
        ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom); dv = 1'($urandom);
            tick();
            if (i == 0) begin
                sq = bus3.q; sv = bus3.q_valid; sf = bus3.fill;
            end else begin
                n_cmp++;
                if (bus3.q !== sq || bus3.q_valid !== sv || bus3.fill !== sf) begin
                    n_bad++;
                    $display("FAIL ce_hold i=%0d: got q=%h v=%b fill=%0d, expected q=%h v=%b fill=%0d", i, bus3.q, bus3.q_valid, bus3.fill, sq, sv, sf);
                end
            end
        end
        ce = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 8'h33 + 8'(i * 16'h11); dv = 1'b1;
            tick();
            e = exp_out(int'(sel5), 5);
            n_cmp++;
            if (bus5.q_valid !== e.vld || (e.vld && bus5.q !== e.dat) || bus5.fill !== 3'(mfill(5))) begin
                n_bad++;
                $display("FAIL ce_resume i=%0d: got q=%h v=%b fill=%0d, expected q=%h v=%b fill=%0d", i, bus5.q, bus5.q_valid, bus5.fill, e.dat, e.vld, mfill(5));
            end
        end
    endtask

    task automatic test_fill();
        int exp_f;
        flush = 1'b1; ce = 1'b1; tick();
        flush = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            d = 8'($urandom); dv = (i <= 10);
            tick();
            exp_f = (i <= 10) ? ((i < 3) ? i : 3) : (13 - i);
            n_cmp++;
            if (bus3.fill !== 2'(exp_f) || bus5.fill !== 3'(mfill(5))) begin
                n_bad++;
                $display("FAIL fill i=%0d: got fill3=%0d fill5=%0d, expected fill3=%0d fill5=%0d", i, bus3.fill, bus5.fill, exp_f, mfill(5));
            end
        end
    endtask

    task automatic test_flush();
        ent_t e;
        sel3 = 2'd3; sel5 = 3'd3;
        ce = 1'b1; dv = 1'b1;
        for (int i = 0; i < 5; i++) begin d = 8'($urandom); tick(); end
        flush = 1'b1; d = 8'hEE;
        tick();
        n_cmp++;
        if (bus3.fill !== 2'd0 || bus5.fill !== 3'd0 || bus3.q_valid !== 1'b0 || bus5.q_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush: got fill3=%0d fill5=%0d v3=%b v5=%b, expected all 0", bus3.fill, bus5.fill, bus3.q_valid, bus5.q_valid);
        end
        flush = 1'b0; ce = 1'b0;
        for (int s = 1; s <= 3; s++) begin
            sel3 = 2'(s); sel5 = 3'(s + 2);
            tick();
            n_cmp++;
            if (bus3.q_valid !== 1'b0 || bus5.q_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL flush_taps sel=%0d: got v3=%b v5=%b, expected 0 0", s, bus3.q_valid, bus5.q_valid);
            end
        end
        sel3 = 2'd1; ce = 1'b1; dv = 1'b0;
        tick();
        e = exp_out(1, 3);
        n_cmp++;
        if (bus3.q_valid !== e.vld || bus3.q_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_drop: got v=%b, expected v=0", bus3.q_valid);
        end
    endtask

    task automatic test_out_of_range();
        ent_t e;
        sel5 = 3'd7; sel3 = 2'd3;
        for (int i = 0; i < 10; i++) begin
            ce = 1'b1; d = 8'($urandom); dv = 1'($urandom_range(0, 3) != 0);
            tick();
            e = exp_out(5, 5);
            n_cmp++;
            if (bus5.q_valid !== e.vld || (e.vld && bus5.q !== e.dat)) begin
                n_bad++;
                $display("FAIL out_of_range i=%0d: got q=%h v=%b, expected q=%h v=%b", i, bus5.q, bus5.q_valid, e.dat, e.vld);
            end
        end
    endtask

    task automatic test_random();
        ent_t e3, e5;
        for (int i = 0; i < 300; i++) begin
            ce    = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            d     = 8'($urandom);
            dv    = 1'($urandom);
            sel3  = 2'($urandom_range(0, 3));
            sel5  = 3'($urandom_range(0, 7));
            tick();
            e3 = exp_out(int'(sel3), 3);
            e5 = exp_out(int'(sel5), 5);
            n_cmp++;
            if (bus3.q_valid !== e3.vld || (e3.vld && bus3.q !== e3.dat) || bus3.fill !== 2'(mfill(3))) begin
                n_bad++;
                $display("FAIL random3 i=%0d: got q=%h v=%b fill=%0d, expected q=%h v=%b fill=%0d", i, bus3.q, bus3.q_valid, bus3.fill, e3.dat, e3.vld, mfill(3));
            end
            n_cmp++;
            if (bus5.q_valid !== e5.vld || (e5.vld && bus5.q !== e5.dat) || bus5.fill !== 3'(mfill(5))) begin
                n_bad++;
                $display("FAIL random5 i=%0d: got q=%h v=%b fill=%0d, expected q=%h v=%b fill=%0d", i, bus5.q, bus5.q_valid, bus5.fill, e5.dat, e5.vld, mfill(5));
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        do_reset_assert();
        repeat (2) @(posedge clk);
        #3;
        areset_n = 1'b1;
        test_reset();
        test_sweep();
        test_ce_gating();
        test_fill();
        test_flush();
        test_out_of_range();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
